// File: rtl/spi_line_fetcher_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_line_fetcher_if
// Purpose  : Signal bundle between the display parent and the line fetcher:
//            fetch request, line-buffer read port and the SPI flash pins.
// Revision : 1.0  initial release
// ============================================================================
interface spi_line_fetcher_if;
  logic        start;
  logic [23:0] addr;
  logic        swap;
  logic        busy;
  logic        done;
  logic        rd_next;
  logic        rd_bit;
  logic        rd_valid;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;

  // Parent / display side: issues requests and consumes pixel bits.
  modport master (
    output start, addr, swap, rd_next, spi_miso,
    input  busy, done, rd_bit, rd_valid, spi_cs, spi_sclk, spi_mosi
  );

  // Fetcher side.
  modport slave (
    input  start, addr, swap, rd_next, spi_miso,
    output busy, done, rd_bit, rd_valid, spi_cs, spi_sclk, spi_mosi
  );
endinterface
`default_nettype wire

// File: rtl/spi_line_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_line_fetcher
// Purpose  : SPI READ (03h) burst into one bank of a two-bank line buffer
//            while the other bank is streamed out one pixel bit at a time.
// Revision : 1.0  initial release
// ============================================================================
module spi_line_fetcher #(
  parameter int         FETCH_BITS = 128,
  parameter logic [7:0] SPI_CMD    = 8'h03
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  spi_line_fetcher_if.slave bus
);
  localparam int IDX_W = $clog2(FETCH_BITS);
  // Counter must reach 23 in ADDR even for the smallest FETCH_BITS.
  localparam int CNT_W = (IDX_W > 5) ? IDX_W : 5;

  localparam logic [CNT_W-1:0] c_cmd_last  = CNT_W'(7);
  localparam logic [CNT_W-1:0] c_addr_last = CNT_W'(23);
  localparam logic [CNT_W-1:0] c_data_last = CNT_W'(FETCH_BITS - 1);
  // GAP spans three internal cycles; the pins lag the FSM by one register,
  // so the bus sees two cs-low cycles before done.
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(2);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [IDX_W:0]   c_ptr_end   = (IDX_W + 1)'(FETCH_BITS);
  localparam logic [IDX_W:0]   c_ptr_one   = (IDX_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic                 r_phase;
  logic [31:0]          r_shift;
  logic                 r_cs, r_sclk, r_mosi;
  logic                 r_busy, r_done;
  logic                 r_sel;
  logic [1:0]           r_valid;
  logic                 r_swap_pend;
  logic [IDX_W:0]       r_rd_ptr;
  logic [FETCH_BITS-1:0] r_bank [2];

  logic w_start_ok, w_data_end, w_gap_end;
  logic w_active, w_do_swap, w_wbank, w_fill_bank, w_rd_in_range;

  assign w_active   = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  // Pending swaps run in the cycle after done; r_done is only ever high in IDLE.
  assign w_do_swap  = ((r_state == S_IDLE) && bus.swap) || (r_done && r_swap_pend);
  assign w_wbank    = ~r_sel;
  // Bank that a newly accepted burst will fill, after any same-cycle swap.
  assign w_fill_bank = ~(r_sel ^ w_do_swap);

  // FSM next state, bit counter and burst event strobes
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_start_ok   = 1'b0;
    w_data_end   = 1'b0;
    w_gap_end    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_CMD;
          w_cnt_next   = '0;
          w_start_ok   = 1'b1;
        end
      end
      S_CMD: begin
        if (r_phase) begin
          if (r_cnt == c_cmd_last) begin
            w_state_next = S_ADDR;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + c_cnt_one;
          end
        end
      end
      S_ADDR: begin
        if (r_phase) begin
          if (r_cnt == c_addr_last) begin
            w_state_next = S_DATA;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + c_cnt_one;
          end
        end
      end
      S_DATA: begin
        if (r_phase) begin
          if (r_cnt == c_data_last) begin
            w_state_next = S_GAP;
            w_cnt_next   = '0;
            w_data_end   = 1'b1;
          end else begin
            w_cnt_next = r_cnt + c_cnt_one;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_gap_end    = 1'b1;
        end else begin
          w_cnt_next = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // FSM state and bit counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // SPI pin generation, registered one cycle behind the FSM; sclk rises when the FSM leaves phase 1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 1'b0;
      r_shift <= '0;
      r_cs    <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_phase <= w_active ? ~r_phase : 1'b0;
      if (w_start_ok) begin
        r_shift <= {SPI_CMD, bus.addr};
      end else if (w_active && r_phase) begin
        r_shift <= {r_shift[30:0], 1'b0};
      end
      r_cs   <= w_active;
      r_sclk <= w_active & r_phase;
      r_mosi <= w_active & r_shift[31];
      r_busy <= (r_state != S_IDLE) & ~w_gap_end;
      r_done <= w_gap_end;
    end
  end

  // Bank select, valid flags, deferred swap and read pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel       <= 1'b0;
      r_valid     <= 2'b00;
      r_swap_pend <= 1'b0;
      r_rd_ptr    <= '0;
    end else begin
      if (w_do_swap) begin
        r_sel <= ~r_sel;
      end
      if (w_do_swap) begin
        r_swap_pend <= 1'b0;
      end else if (bus.swap && (r_state != S_IDLE)) begin
        r_swap_pend <= 1'b1;
      end
      if (w_start_ok) begin
        r_valid[w_fill_bank] <= 1'b0;
      end
      if (w_data_end) begin
        r_valid[w_wbank] <= 1'b1;
      end
      if (w_do_swap) begin
        r_rd_ptr <= '0;
      end else if (bus.rd_next && (r_rd_ptr != c_ptr_end)) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Capture MISO into the write bank on the edge that raises sclk; contents need no reset
  always_ff @(posedge clk) begin
    if ((r_state == S_DATA) && r_phase) begin
      r_bank[w_wbank][r_cnt[IDX_W-1:0]] <= bus.spi_miso;
    end
  end

  assign w_rd_in_range = (r_rd_ptr != c_ptr_end);

  assign bus.rd_bit   = r_valid[r_sel] & w_rd_in_range & r_bank[r_sel][r_rd_ptr[IDX_W-1:0]];
  assign bus.rd_valid = r_valid[r_sel];
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.spi_cs   = r_cs;
  assign bus.spi_sclk = r_sclk;
  assign bus.spi_mosi = r_mosi;
endmodule
`default_nettype wire

// File: tb/tb_spi_line_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_line_fetcher
// Purpose  : Scenario bench for spi_line_fetcher with an SPI flash model and
//            a queue of expected line contents.
// Revision : 1.0  initial release
// ============================================================================
module tb_spi_line_fetcher;
  localparam int FB = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  spi_line_fetcher_if bus_if ();

  spi_line_fetcher #(.FETCH_BITS(FB), .SPI_CMD(8'h03)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Flash model: shifts in command/address on sclk rise, drives data on sclk fall.
  logic [FB-1:0] fl_data;
  logic [31:0]   fl_cap;
  int            fl_cnt = 0;
  always @(posedge bus_if.spi_sclk or negedge bus_if.spi_cs) begin
    if (!bus_if.spi_cs) begin
      fl_cnt <= 0;
    end else begin
      if (fl_cnt < 32) fl_cap <= {fl_cap[30:0], bus_if.spi_mosi};
      fl_cnt <= fl_cnt + 1;
    end
  end
  always @(negedge bus_if.spi_sclk) begin
    if (bus_if.spi_cs && fl_cnt >= 32 && fl_cnt < 32 + FB) bus_if.spi_miso <= fl_data[fl_cnt-32];
  end

  logic [FB-1:0] exp_q[$];

  // Observations collected by run_burst
  int       t0, done_rel, done_cnt, cs_cnt;
  logic [1:0] obs_pre;
  logic [3:0] obs_first;
  logic     mosi_bad, busy_bad, busy_at_done;
  logic     v_mid, b_mid, v_done, b_done, v_done1, b_done1;

  task automatic run_burst(input logic [23:0] a, input logic [FB-1:0] d,
                           input int swap_at, input int start_at, input bit swap_with);
    int r;
    fl_data = d;
    exp_q.push_back(d);
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.addr = a; bus_if.swap = swap_with;
    @(negedge clk);
    bus_if.start = 1'b0; bus_if.swap = 1'b0; bus_if.addr = ~a;
    t0 = cyc;
    done_rel = -1; done_cnt = 0; cs_cnt = 0; mosi_bad = 1'b0; busy_bad = 1'b0;
    obs_pre = 2'bxx; obs_first = 4'bxxxx; busy_at_done = 1'bx;
    v_mid = 1'bx; b_mid = 1'bx; v_done = 1'bx; b_done = 1'bx; v_done1 = 1'bx; b_done1 = 1'bx;
    for (int k = 0; k < 700; k++) begin
      r = cyc - t0;
      if (r == 0) obs_pre = {bus_if.spi_cs, bus_if.busy};
      if (r == 1) obs_first = {bus_if.spi_cs, bus_if.busy, bus_if.spi_sclk, bus_if.spi_mosi};
      if (r == 150) begin v_mid = bus_if.rd_valid; b_mid = bus_if.rd_bit; end
      if (bus_if.spi_cs) cs_cnt++;
      if (bus_if.spi_cs && r >= 65 && bus_if.spi_mosi) mosi_bad = 1'b1;
      if (r >= 1 && done_rel < 0 && !bus_if.done && !bus_if.busy) busy_bad = 1'b1;
      if (bus_if.done) begin
        done_cnt++;
        if (done_rel < 0) begin
          done_rel = r; v_done = bus_if.rd_valid; b_done = bus_if.rd_bit; busy_at_done = bus_if.busy;
        end
      end
      if (done_rel >= 0 && r == done_rel + 1) begin
        v_done1 = bus_if.rd_valid; b_done1 = bus_if.rd_bit;
        break;
      end
      bus_if.swap  = (r + 1 == swap_at);
      bus_if.start = (r + 1 == start_at);
      @(negedge clk);
    end
    bus_if.swap = 1'b0; bus_if.start = 1'b0;
  endtask

  task automatic do_swap();
    @(negedge clk); bus_if.swap = 1'b1;
    @(negedge clk); bus_if.swap = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++; if ({bus_if.spi_cs, bus_if.spi_sclk, bus_if.spi_mosi} !== 3'b000) begin
      miscompares++; $display("FAIL reset_spi_pins: got %b expected 000", {bus_if.spi_cs, bus_if.spi_sclk, bus_if.spi_mosi}); end
    vectors++; if ({bus_if.busy, bus_if.done} !== 2'b00) begin
      miscompares++; $display("FAIL reset_busy_done: got %b expected 00", {bus_if.busy, bus_if.done}); end
    vectors++; if ({bus_if.rd_valid, bus_if.rd_bit} !== 2'b00) begin
      miscompares++; $display("FAIL reset_read_port: got %b expected 00", {bus_if.rd_valid, bus_if.rd_bit}); end
  endtask

  task automatic test_drain_bank();
    logic [FB-1:0] expv, got;
    if (exp_q.size() == 0) begin
      vectors++; miscompares++; $display("FAIL drain_queue: got empty expected an entry");
      return;
    end
    expv = exp_q.pop_front();
    @(negedge clk);
    vectors++; if (bus_if.rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL drain_valid: got %b expected 1", bus_if.rd_valid); end
    for (int i = 0; i < FB; i++) begin
      got[i] = bus_if.rd_bit;
      bus_if.rd_next = 1'b1;
      @(negedge clk);
    end
    bus_if.rd_next = 1'b0;
    vectors++; if (got !== expv) begin
      miscompares++; $display("FAIL drain_stream: got %h expected %h", got, expv); end
    vectors++; if (bus_if.rd_bit !== 1'b0) begin
      miscompares++; $display("FAIL drain_end_bit: got %b expected 0", bus_if.rd_bit); end
    bus_if.rd_next = 1'b1; @(negedge clk); bus_if.rd_next = 1'b0;
    vectors++; if ({bus_if.rd_valid, bus_if.rd_bit} !== 2'b10) begin
      miscompares++; $display("FAIL drain_saturate: got %b expected 10", {bus_if.rd_valid, bus_if.rd_bit}); end
  endtask

  task automatic test_burst_timing();
    run_burst(24'h000120, {16{8'hA5}}, -1, -1, 1'b0);
    vectors++; if (done_rel !== 323) begin
      miscompares++; $display("FAIL timing_done_cycle: got %0d expected 323", done_rel); end
    vectors++; if (done_cnt !== 1) begin
      miscompares++; $display("FAIL timing_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (cs_cnt !== 320) begin
      miscompares++; $display("FAIL timing_cs_cycles: got %0d expected 320", cs_cnt); end
    vectors++; if (fl_cap !== 32'h03000120) begin
      miscompares++; $display("FAIL timing_mosi_seq: got %h expected 03000120", fl_cap); end
    vectors++; if (obs_pre !== 2'b00) begin
      miscompares++; $display("FAIL timing_accept_cycle: got %b expected 00", obs_pre); end
    vectors++; if (obs_first !== 4'b1100) begin
      miscompares++; $display("FAIL timing_first_cycle: got %b expected 1100", obs_first); end
    vectors++; if (mosi_bad !== 1'b0) begin
      miscompares++; $display("FAIL timing_data_mosi: got %b expected 0", mosi_bad); end
    vectors++; if ({busy_bad, busy_at_done} !== 2'b00) begin
      miscompares++; $display("FAIL timing_busy: got %b expected 00", {busy_bad, busy_at_done}); end
    vectors++; if (bus_if.rd_valid !== 1'b0) begin
      miscompares++; $display("FAIL timing_read_bank_empty: got %b expected 0", bus_if.rd_valid); end
  endtask

  task automatic test_readout();
    do_swap();
    test_drain_bank();
  endtask

  task automatic test_mid_swap();
    logic [FB-1:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[0] = 1'b1;
    run_burst(24'h001000, p, 100, -1, 1'b0);
    vectors++; if (done_rel !== 323) begin
      miscompares++; $display("FAIL midswap_done_cycle: got %0d expected 323", done_rel); end
    vectors++; if ({v_mid, b_mid} !== 2'b10) begin
      miscompares++; $display("FAIL midswap_during_burst: got %b expected 10", {v_mid, b_mid}); end
    vectors++; if ({v_done, b_done} !== 2'b10) begin
      miscompares++; $display("FAIL midswap_at_done: got %b expected 10", {v_done, b_done}); end
    vectors++; if ({v_done1, b_done1} !== 2'b11) begin
      miscompares++; $display("FAIL midswap_after_done: got %b expected 11", {v_done1, b_done1}); end
    test_drain_bank();
  endtask

  task automatic test_busy_start();
    run_burst(24'hABCDEF, {$urandom, $urandom, $urandom, $urandom}, -1, 50, 1'b0);
    vectors++; if (done_rel !== 323) begin
      miscompares++; $display("FAIL busystart_done_cycle: got %0d expected 323", done_rel); end
    vectors++; if (done_cnt !== 1) begin
      miscompares++; $display("FAIL busystart_done_count: got %0d expected 1", done_cnt); end
    vectors++; if (fl_cap !== 32'h03ABCDEF) begin
      miscompares++; $display("FAIL busystart_mosi_seq: got %h expected 03abcdef", fl_cap); end
  endtask

  task automatic test_start_swap();
    run_burst(24'h00F00D, {$urandom, $urandom, $urandom, $urandom}, -1, -1, 1'b1);
    vectors++; if (done_rel !== 323) begin
      miscompares++; $display("FAIL startswap_done_cycle: got %0d expected 323", done_rel); end
    vectors++; if (bus_if.rd_valid !== 1'b1) begin
      miscompares++; $display("FAIL startswap_read_valid: got %b expected 1", bus_if.rd_valid); end
    test_drain_bank();
    do_swap();
    test_drain_bank();
  endtask

  task automatic test_reset_midburst();
    int r;
    fl_data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus_if.start = 1'b1; bus_if.addr = 24'h123456;
    @(negedge clk);
    bus_if.start = 1'b0;
    t0 = cyc;
    for (int k = 0; k < 200; k++) begin
      r = cyc - t0;
      if (r >= 150) break;
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({bus_if.spi_cs, bus_if.spi_sclk, bus_if.spi_mosi} !== 3'b000) begin
      miscompares++; $display("FAIL arst_spi_pins: got %b expected 000", {bus_if.spi_cs, bus_if.spi_sclk, bus_if.spi_mosi}); end
    vectors++; if ({bus_if.busy, bus_if.done, bus_if.rd_valid} !== 3'b000) begin
      miscompares++; $display("FAIL arst_status: got %b expected 000", {bus_if.busy, bus_if.done, bus_if.rd_valid}); end
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    run_burst(24'h0A0B0C, {$urandom, $urandom, $urandom, $urandom}, -1, -1, 1'b0);
    vectors++; if (done_rel !== 323) begin
      miscompares++; $display("FAIL arst_restart_done: got %0d expected 323", done_rel); end
    vectors++; if (cs_cnt !== 320) begin
      miscompares++; $display("FAIL arst_restart_cs: got %0d expected 320", cs_cnt); end
    vectors++; if (fl_cap !== 32'h030A0B0C) begin
      miscompares++; $display("FAIL arst_restart_mosi: got %h expected 030a0b0c", fl_cap); end
    do_swap();
    test_drain_bank();
  endtask

  task automatic test_idle_quiet();
    logic [2:0] acc;
    acc = 3'b000;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      acc = acc | {bus_if.spi_sclk, bus_if.spi_cs, bus_if.spi_mosi};
    end
    vectors++; if (acc !== 3'b000) begin
      miscompares++; $display("FAIL idle_quiet: got %b expected 000", acc); end
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.addr = 24'h0;
    bus_if.swap = 1'b0;
    bus_if.rd_next = 1'b0;
    test_reset();
    test_burst_timing();
    test_readout();
    test_mid_swap();
    test_busy_start();
    test_start_swap();
    test_reset_midburst();
    test_idle_quiet();
    vectors++; if (exp_q.size() !== 0) begin
      miscompares++; $display("FAIL queue_leftover: got %0d expected 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/spi_line_fetcher.md
# spi_line_fetcher

Upstream fetch stage for the VGA SPI-ROM display path. It runs an SPI READ (03h) burst from a 24-bit address, captures FETCH_BITS data bits into one bank of a two-bank line buffer, and presents the other bank as a serial pixel-bit stream. This lets the display stage show a full row without touching the SPI bus during active video.

## Interface
- FETCH_BITS, 128: data bits read per burst and the size of each buffer bank. Must be a power of two, 8..512.
- SPI_CMD, 8'h03: command byte sent MSB-first.
- clk  input  1  system clock (pixel clock).
- reset_n  input  1  reset. One clock domain; reset is asynchronous and active-low.
- start  input  1  one-cycle request to fetch; honoured only in IDLE.
- addr  input  24  flash byte address; latched on an accepted start.
- swap  input  1  one-cycle request to exchange the read and write banks and rewind the read pointer.
- busy  output  1  high from the cycle after an accepted start until DONE completes.
- done  output  1  one-cycle pulse when a burst completes.
- rd_next  input  1  advance the read pointer by one bit.
- rd_bit  output  1  current bit of the read bank.
- rd_valid  output  1  the read bank holds a complete burst.
- spi_cs  output  1  chip select, active HIGH. The parent inverts it.
- spi_sclk  output  1  registered SPI clock, clk/2, mode 0.
- spi_mosi  output  1  serial command and address.
- spi_miso  input  1  serial data from the flash.

## Operation
- FSM states: IDLE, CMD (8 bits), ADDR (24 bits), DATA (FETCH_BITS bits), GAP (2 cycles), then back to IDLE.
- Each SPI bit takes 2 clk cycles:
  - phase 0: spi_sclk=0, and MOSI updates at the start of this phase;
  - phase 1: spi_sclk=1.
- spi_miso is sampled on the clk edge that drives spi_sclk 0→1.
- MOSI sequence: SPI_CMD[7:0], then the latched addr[23:0], both MSB-first. During DATA and GAP, spi_mosi=0.
- spi_cs=1 in CMD, ADDR and DATA, and 0 in IDLE and GAP.
- spi_sclk=0 whenever spi_cs=0.
- The write bank fills MSB-first: the first DATA bit goes to index 0 and the last to index FETCH_BITS-1.
- Bank valid flags:
  - on leaving DATA, the write bank's valid flag is set;
  - on an accepted start, the write bank's valid flag is cleared.
- rd_bit = read_bank[rd_ptr].
  - rd_next increments rd_ptr.
  - rd_ptr saturates at FETCH_BITS. While rd_ptr = FETCH_BITS, rd_bit=0.
  - If rd_valid=0, rd_bit=0.
- swap handling:
  - in IDLE, swap exchanges the banks and sets rd_ptr=0 on the next edge;
  - while busy, swap sets a pending flag, and the swap executes on the cycle after done;
  - further swaps while a swap is pending collapse into one.
- Simultaneous events:
  - start and swap in the same IDLE cycle: the swap takes effect first, so the burst fills the new write bank;
  - start while busy is ignored, with no queueing;
  - rd_next together with swap: swap wins and rd_ptr=0.
- Reset (asynchronous, including mid-burst):
  - FSM returns to IDLE;
  - spi_cs=0, spi_sclk=0, spi_mosi=0;
  - busy=0, done=0;
  - both valid flags cleared, rd_ptr=0, bank select=0, pending swap cleared;
  - buffer contents are undefined.

## Timing
- Accepted start at edge T:
  - at T+1: busy=1, spi_cs=1, spi_sclk=0, spi_mosi=SPI_CMD[7];
  - first spi_sclk rise at T+2.
- Bit k (k=0 is CMD[7]) occupies cycles T+1+2k (sclk low) and T+2+2k (sclk high).
- DATA bit j is sampled at edge T+2+2(32+j).
- The last sample is at T+2+2(31+FETCH_BITS).
- GAP occupies the next 2 cycles with spi_cs=0.
- done=1 for exactly one cycle at T+2(32+FETCH_BITS)+3, with busy dropping on the same edge. For FETCH_BITS=128 this is T+323.
- A pending swap executes at done+1. The next start is accepted at the earliest at done+1.
- rd_bit is combinational from the registered rd_ptr and the bank, so it is valid the same cycle rd_ptr changes.

## Test plan
- Reset, then start with addr=24'h000120 and a flash model: MOSI sequence is 03h then 000120h MSB-first; spi_cs is high for exactly 320 cycles; done pulses once at T+323.
- Flash returns A5h repeated; then swap in IDLE and 128 rd_next pulses: rd_valid=1 and rd_bit stream is 1,0,1,0,0,1,0,1 repeated; bit 128 onward reads 0.
- swap asserted at T+100 mid-burst: banks unchanged until done; swap executes at done+1; rd_ptr=0; new read bank holds the fresh data.
- start at T+50 while busy: no effect. start and swap together in IDLE: fill goes to the post-swap write bank, and the read bank is the previous write bank.
- reset_n low at T+150: spi_cs and spi_sclk are 0 asynchronously, busy=0 and rd_valid=0; a fresh start after release completes normally.
- 1000 cycles with no start: spi_sclk stays 0, spi_cs stays 0, spi_mosi stays 0.
